// File: rtl/bt_pkg.sv
// Shared types and constants for the Bluetooth TX scheduler.
// The optional header state is only reachable when BT_SCHED_HEADER_EN is defined.
package bt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_SEND,
      ST_GUARD,
      ST_WAIT_TX
   } bt_sched_state_e;

   localparam logic [3:0] BT_HDR_NIBBLE = 4'hA;
   localparam logic [7:0] BT_ERR_MAX    = 8'hFF;

endpackage

// File: rtl/bt_rr_pick.sv
// Combinational round-robin picker: first asserted request searching upward
// from ptr+1 with wrap-around; pick is one-hot, any flags a non-empty request set.
module bt_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] pick,
   output logic               any
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      // The requester at ptr is visited last, which is what makes it fair.
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IW'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/bt_tx_scheduler.sv
// Round-robin packet scheduler sharing one HC-05 UART TX path between requesters.
// Define BT_SCHED_HEADER_EN to prefix each packet with the byte {4'hA, owner}.
module bt_tx_scheduler
   import bt_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 bt_state,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   output logic                 timeout_err,
   output logic [7:0]           err_count
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   bt_sched_state_e      state_reg, state_next;
   logic [NUM_REQ-1:0]   grant_reg, grant_next;
   logic [IW-1:0]        g_reg, g_next;
   logic [IW-1:0]        ptr_reg, ptr_next;
   logic                 tx_start_reg, tx_start_next;
   logic [7:0]           tx_data_reg, tx_data_next;
   logic                 last_reg, last_next;
   logic                 drop_reg, drop_next;
   logic [TW-1:0]        stall_reg, stall_next;
   logic                 timeout_reg, timeout_next;
   logic [7:0]           err_reg, err_next;

   logic [NUM_REQ-1:0]   pick;
   logic                 pick_any;
   logic [IW-1:0]        pick_idx;
   logic [7:0]           data_arr [NUM_REQ];
   logic                 sel_valid;
   logic                 sel_last;
   logic [7:0]           sel_data;
   logic                 handshake;

   bt_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_pick (
      .req  (req_valid),
      .ptr  (ptr_reg),
      .pick (pick),
      .any  (pick_any)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_data
         assign data_arr[gi] = req_data[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pick_idx = IW'(i);
      end
   end

   assign sel_valid = req_valid[g_reg];
   assign sel_last  = req_last[g_reg];
   assign sel_data  = data_arr[g_reg];

   assign req_ready = (state_reg == ST_SEND) ? (grant_reg & {NUM_REQ{bt_state & ~tx_busy}})
                                             : '0;
   assign handshake = (state_reg == ST_SEND) && sel_valid && bt_state && !tx_busy;

   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      g_next        = g_reg;
      ptr_next      = ptr_reg;
      tx_start_next = 1'b0;
      tx_data_next  = tx_data_reg;
      last_next     = last_reg;
      drop_next     = drop_reg;
      stall_next    = stall_reg;
      timeout_next  = 1'b0;
      err_next      = err_reg;

      case (state_reg)
         ST_IDLE: begin
            if (bt_state && pick_any) begin
               grant_next = pick;
               g_next     = pick_idx;
               drop_next  = 1'b0;
`ifdef BT_SCHED_HEADER_EN
               state_next = ST_HDR;
`else
               state_next = ST_SEND;
`endif
            end
         end
`ifdef BT_SCHED_HEADER_EN
         ST_HDR: begin
            if (!bt_state) begin
               ptr_next   = g_reg;
               grant_next = '0;
               state_next = ST_IDLE;
            end else if (!tx_busy) begin
               tx_data_next  = {BT_HDR_NIBBLE, 4'(g_reg)};
               tx_start_next = 1'b1;
               last_next     = 1'b0;
               state_next    = ST_GUARD;
            end
         end
`endif
         ST_SEND: begin
            // A dropped link takes precedence over the stall timer and is not an error.
            if (!bt_state) begin
               ptr_next   = g_reg;
               grant_next = '0;
               stall_next = '0;
               state_next = ST_IDLE;
            end else if (handshake) begin
               tx_data_next  = sel_data;
               tx_start_next = 1'b1;
               last_next     = sel_last;
               stall_next    = '0;
               state_next    = ST_GUARD;
            end else if (!sel_valid) begin
               if (stall_reg == TW'(TIMEOUT - 1)) begin
                  timeout_next = 1'b1;
                  if (err_reg != BT_ERR_MAX) err_next = err_reg + 8'd1;
                  ptr_next     = g_reg;
                  grant_next   = '0;
                  stall_next   = '0;
                  state_next   = ST_IDLE;
               end else begin
                  stall_next = stall_reg + TW'(1);
               end
            end
         end
         ST_GUARD: begin
            if (!bt_state) drop_next = 1'b1;
            state_next = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (!bt_state) drop_next = 1'b1;
            // A link drop seen during the byte ends the packet once the byte is out.
            if (!tx_busy) begin
               if (last_reg || drop_reg || !bt_state) begin
                  ptr_next   = g_reg;
                  grant_next = '0;
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_SEND;
               end
            end
         end
         default: begin
            grant_next = '0;
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         grant_reg    <= '0;
         g_reg        <= '0;
         ptr_reg      <= IW'(NUM_REQ - 1);
         tx_start_reg <= 1'b0;
         tx_data_reg  <= 8'h00;
         last_reg     <= 1'b0;
         drop_reg     <= 1'b0;
         stall_reg    <= '0;
         timeout_reg  <= 1'b0;
         err_reg      <= 8'h00;
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         g_reg        <= g_next;
         ptr_reg      <= ptr_next;
         tx_start_reg <= tx_start_next;
         tx_data_reg  <= tx_data_next;
         last_reg     <= last_next;
         drop_reg     <= drop_next;
         stall_reg    <= stall_next;
         timeout_reg  <= timeout_next;
         err_reg      <= err_next;
      end
   end

   assign grant       = grant_reg;
   assign tx_start    = tx_start_reg;
   assign tx_data     = tx_data_reg;
   assign timeout_err = timeout_reg;
   assign err_count   = err_reg;

endmodule

// File: tb/tb_bt_tx_scheduler.sv
// Directed bench for bt_tx_scheduler with a busy-for-10-cycles UART model.
// With BT_SCHED_HEADER_EN defined the header path replaces the raw-byte steps.
module tb_bt_tx_scheduler;

   localparam int N = 4;

   logic            clock = 1'b0;
   logic            reset;
   logic            bt_state;
   logic [N-1:0]    req_valid;
   logic [8*N-1:0]  req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    grant;
   logic            tx_start;
   logic [7:0]      tx_data;
   logic            tx_busy;
   logic            timeout_err;
   logic [7:0]      err_count;

   int              total = 0;
   int              bad   = 0;
   int              busy_cnt;
   logic [7:0]      txq [$];
   logic [N-1:0]    gq  [$];

   always #5 clock = ~clock;

   bt_tx_scheduler #(
      .NUM_REQ (N),
      .TIMEOUT (20)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .bt_state    (bt_state),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .grant       (grant),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .timeout_err (timeout_err),
      .err_count   (err_count)
   );

   // UART model: busy for 10 cycles after each load.
   always @(posedge clock) begin
      if (reset)             busy_cnt <= 0;
      else if (tx_start)     busy_cnt <= 10;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_busy = (busy_cnt != 0);

   always @(negedge clock) begin
      if (!reset && tx_start) begin
         txq.push_back(tx_data);
         gq.push_back(grant);
         $display("tx byte=%02h grant=%b", tx_data, grant);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic push_byte(input int r, input logic [7:0] d, input logic l);
      int n;
      n = 0;
      req_valid[r]       = 1'b1;
      req_data[8*r +: 8] = d;
      req_last[r]        = l;
      while (!req_ready[r] && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("ready_wait_bound", 32'(n < 200), 32'd1);
      @(negedge clock);
      req_valid[r] = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(grant == '0 && !tx_busy) && n < 200) begin
         @(negedge clock);
         n++;
      end
      check("idle_wait_bound", 32'(n < 200), 32'd1);
   endtask

   initial begin
      int base;
      int cnt;
      reset     = 1'b1;
      bt_state  = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      repeat (3) @(negedge clock);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_tx_start", 32'(tx_start), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);
      check("rst_timeout", 32'(timeout_err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("post_rst_grant", 32'(grant), 32'd0);

`ifdef BT_SCHED_HEADER_EN
      base = txq.size();
      push_byte(2, 8'h55, 1'b1);
      wait_idle();
      check("hdr_byte", 32'(txq[base]), 32'hA2);
      check("hdr_data", 32'(txq[base+1]), 32'h55);
      check("hdr_grant", 32'(gq[base]), 32'b0100);
      check("hdr_grant_clear", 32'(grant), 32'd0);
`else
      // Single requester with first-byte latency.
      req_data[7:0] = 8'h41;
      req_last[0]   = 1'b0;
      req_valid[0]  = 1'b1;
      @(negedge clock);
      check("first_grant", 32'(grant), 32'b0001);
      check("first_ready", 32'(req_ready), 32'b0001);
      @(negedge clock);
      req_valid[0] = 1'b0;
      check("first_tx_start", 32'(tx_start), 32'd1);
      check("first_tx_data", 32'(tx_data), 32'h41);
      check("grant_hold_guard", 32'(grant), 32'b0001);
      push_byte(0, 8'h42, 1'b1);
      check("grant_hold_second", 32'(grant), 32'b0001);
      wait_idle();
      check("single_grant_clear", 32'(grant), 32'd0);
      check("single_b0", 32'(txq[0]), 32'h41);
      check("single_b1", 32'(txq[1]), 32'h42);
      check("single_g1", 32'(gq[1]), 32'b0001);
`endif

      // Reset during WAIT_TX.
      push_byte(1, 8'h77, 1'b0);
      repeat (2) @(negedge clock);
      check("mid_busy", 32'(tx_busy), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      check("mid_rst_grant", 32'(grant), 32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd0);
      check("mid_rst_tx_start", 32'(tx_start), 32'd0);
      check("mid_rst_tx_data", 32'(tx_data), 32'd0);
      check("mid_rst_timeout", 32'(timeout_err), 32'd0);
      check("mid_rst_err", 32'(err_count), 32'd0);
      reset = 1'b0;
      @(negedge clock);

`ifndef BT_SCHED_HEADER_EN
      // Round-robin between requesters 0 and 2, 1-byte packets.
      base = txq.size();
      req_data[7:0]   = 8'h10;
      req_data[23:16] = 8'h20;
      req_last        = 4'b0101;
      req_valid       = 4'b0101;
      for (int n = 0; n < 300; n++) begin
         if (txq.size() >= base + 4) break;
         @(negedge clock);
      end
      req_valid = '0;
      req_last  = '0;
      check("rr_count", 32'(txq.size() >= base + 4), 32'd1);
      check("rr_g0", 32'(gq[base]),   32'b0001);
      check("rr_g1", 32'(gq[base+1]), 32'b0100);
      check("rr_g2", 32'(gq[base+2]), 32'b0001);
      check("rr_g3", 32'(gq[base+3]), 32'b0100);
      check("rr_d1", 32'(txq[base+1]), 32'h20);
      wait_idle();

      // Disconnected link holds off grants.
      bt_state         = 1'b0;
      req_data[15:8]   = 8'h31;
      req_last[1]      = 1'b1;
      req_valid[1]     = 1'b1;
      base = txq.size();
      repeat (10) @(negedge clock);
      check("disc_grant", 32'(grant), 32'd0);
      check("disc_no_tx", 32'(txq.size()), 32'(base));
      bt_state = 1'b1;
      @(negedge clock);
      check("conn_grant", 32'(grant), 32'b0010);
      check("conn_ready", 32'(req_ready), 32'b0010);
      @(negedge clock);
      req_valid[1] = 1'b0;
      req_last[1]  = 1'b0;
      check("conn_tx_start", 32'(tx_start), 32'd1);
      check("conn_tx_data", 32'(tx_data), 32'h31);
      wait_idle();
`endif

      // Stall timeout: one non-last byte then valid drops.
      push_byte(3, 8'h99, 1'b0);
      cnt = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clock);
         if (timeout_err) break;
         if (req_ready[3]) cnt++;
      end
      check("to_pulse", 32'(timeout_err), 32'd1);
      check("to_stall_cycles", 32'(cnt), 32'd20);
      check("to_grant", 32'(grant), 32'd0);
      @(negedge clock);
      check("to_pulse_end", 32'(timeout_err), 32'd0);
      check("to_err_count", 32'(err_count), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bt_tx_scheduler.md
# bt_tx_scheduler

Round-robin packet scheduler that shares the single HC-05 UART transmit path (`fpga_txd`) between up to `NUM_REQ` byte-stream requesters, such as Opal Kelly command echo, status reports and sensor streams. It grants one requester for a whole packet, delimited by `req_last`, and feeds bytes one at a time to the UART transmitter. It gates all traffic on the HC-05 connection state, recovers from stalled requesters with a timeout, and exposes an error counter suitable for an Opal Kelly wireOut. It sits inside `FPGA_Bluetooth_connection`, between the requesters and the UART TX core.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters; range 2–8.
- `TIMEOUT`, 1000 — stall limit in clock cycles, mid-packet; 1 ms at 1 MHz.

Ports:
- `clock`  in  1  — system clock (1 MHz); the block uses one clock.
- `reset`  in  1  — synchronous, active-high reset.
- `bt_state`  in  1  — HC-05 STATE pin; 1 = paired and connected.
- `req_valid`  in  NUM_REQ  — per-requester byte valid.
- `req_data`  in  8*NUM_REQ  — requester i data in bits [8i+7:8i].
- `req_last`  in  NUM_REQ  — byte is the last byte of its packet.
- `req_ready`  out  NUM_REQ  — byte accepted when `valid & ready`.
- `grant`  out  NUM_REQ  — one-hot current owner; 0 when idle.
- `tx_start`  out  1  — one-cycle pulse that loads `tx_data` into the UART TX.
- `tx_data`  out  8  — byte to transmit; valid while `tx_start` = 1.
- `tx_busy`  in  1  — UART TX shifting; rises no later than 1 cycle after `tx_start`.
- `timeout_err`  out  1  — one-cycle pulse on a stall abort.
- `err_count`  out  8  — saturating count of timeout aborts.

## Operation
- States: `IDLE`, `HDR` (macro only), `SEND`, `GUARD`, `WAIT_TX`.
- `IDLE`:
  - If `bt_state` and any `req_valid`: pick the first asserted requester searching upward from `ptr+1`, with wrap.
  - Register the pick in `grant`, then go to `HDR` (if configured) or `SEND`.
- `SEND`:
  - `req_ready[g] = bt_state & ~tx_busy`; every other ready bit is 0.
  - On handshake: `tx_data <= req_data[g]`, `tx_start <= 1`, latch `req_last[g]`, then go to `GUARD`.
- `GUARD`: one cycle in which `tx_busy` is ignored. Always go to `WAIT_TX`.
- `WAIT_TX`: wait for `tx_busy` = 0, then:
  - If the latched last flag is set: `ptr <= g`, `grant <= 0`, go to `IDLE`.
  - Otherwise go to `SEND`.
- Stall timer:
  - Counts cycles in `SEND` with `req_valid[g]` = 0; cleared on every handshake and on leaving `SEND`.
  - Reaching `TIMEOUT`: pulse `timeout_err`, `err_count <= err_count+1` (saturates at 255), `ptr <= g`, `grant <= 0`, go to `IDLE`.
  - The remainder of the aborted packet is seen as a new packet on a later grant.
- `bt_state` falling:
  - In `IDLE`: no grant is issued.
  - In `SEND`: abort to `IDLE` next cycle with no handshake; `ptr <= g`; not counted as an error.
  - In `GUARD` / `WAIT_TX`: the in-flight byte completes, then the packet is aborted.
- Fairness: a requester cannot win twice in a row while another requester is valid in `IDLE`.

## Timing
- Reset values:
  - `grant` = 0, `req_ready` = 0, `tx_start` = 0, `tx_data` = 0, `timeout_err` = 0, `err_count` = 0.
  - State = `IDLE`, `ptr` = NUM_REQ-1, so requester 0 is first.
- A reset asserted mid-packet drops the byte in flight; the UART TX is reset by the same `reset`.
- `req_ready` is combinational from state, `grant`, `bt_state` and `tx_busy`. All other outputs are registered.
- First-byte latency: `req_valid` seen in `IDLE` at cycle 0 → `grant` at 1 → handshake at 1 → `tx_start` at 2.
- Back-to-back bytes: each byte takes the UART frame time plus 2 cycles (`GUARD` + the `WAIT_TX` exit).
- One `IDLE` cycle minimum between packets.
- A 1-byte packet (`req_last` on the first byte) is legal.

## Configuration
- `BT_SCHED_HEADER_EN` defined:
  - After a grant, state `HDR` waits for `~tx_busy`, then sends the header byte `{4'hA, 4'(g)}` through `GUARD`/`WAIT_TX` before entering `SEND`.
  - The timeout is not active in `HDR`.
- `BT_SCHED_HEADER_EN` undefined: `HDR` is not built, and packets are sent raw.

## Structure
- Shared package `bt_pkg` holds:
  - the state enum;
  - `BT_HDR_NIBBLE` = 4'hA;
  - `BT_ERR_MAX` = 8'hFF.
- One sub-module, `bt_rr_pick`: a combinational round-robin priority picker. Inputs are `req` (NUM_REQ) and `ptr`; outputs are a one-hot `pick` and `any`. The FSM, timer and datapath stay in `bt_tx_scheduler`.

## Test plan
- Single requester:
  - Stimulus: req0 sends 0x41, 0x42 (last); `bt_state` = 1; UART model busy for 10 cycles per byte.
  - Response: `tx_start` carries 0x41 then 0x42; `grant` = 0001 throughout, then 0.
- Round-robin:
  - Stimulus: req0 and req2 continuously valid, 1-byte packets.
  - Response: grant order 0, 2, 0, 2; no repeat while the other is valid.
- Disconnect:
  - Stimulus: `bt_state` = 0 with req1 valid.
  - Response: `grant` stays 0 and no `tx_start`. Raising `bt_state` grants req1 within 1 cycle.
- Stall timeout:
  - Stimulus: with `TIMEOUT` = 20, req3 sends one non-last byte, then drops valid.
  - Response: after 20 cycles, one `timeout_err` pulse; `err_count` = 1; `grant` = 0.
- Reset mid-packet:
  - Stimulus: assert `reset` during `WAIT_TX`.
  - Response: next cycle all outputs hold their reset values and `ptr` favours req0.
- Header build:
  - Stimulus: `BT_SCHED_HEADER_EN` defined; req2 sends 0x55 (last).
  - Response: `tx_start` bytes are 0xA2 then 0x55.
